sdb_frame_tx: RTL and testbench

//  Parametrised 16-bit event/data stream generator for the SFP 8b/10b link; drives gtpwizard tx_data/txcharisk.
//  LSB lane: event stream (periodic K28.5 comma, periodic beacon, host event codes via valid/ready).
//  MSB lane alternates: even slots carry the distributed-bus byte; odd slots carry segmented-data-buffer frames.

---
 rtl/sdb_frame_tx.sv | 169 ++++++++++++++++
 tb/tb_sdb_frame_tx.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdb_frame_tx.sv
// sdb_frame_tx: 16-bit SFP transmit word generator.
// LSB lane carries the event stream: periodic K28.5 comma, periodic beacon and host event codes.
// MSB lane alternates between the distributed-bus byte (phase 0) and segmented-data-buffer
// frame bytes (phase 1). Frames are read from an internal payload RAM.
module sdb_frame_tx #(
  parameter int         SEG_BYTES     = 16,
  parameter int         NUM_SEG       = 16,
  parameter int         COMMA_PERIOD  = 4,
  parameter int         BEACON_PERIOD = 7,
  parameter logic [7:0] BEACON_CODE   = 8'h7E,
  localparam int        AW            = $clog2(NUM_SEG * SEG_BYTES),
  localparam int        SW            = $clog2(NUM_SEG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          link_ready,
  input  logic [7:0]    dbus,
  input  logic          evt_valid,
  input  logic [7:0]    evt_code,
  output logic          evt_ready,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          seg_valid,
  input  logic [SW-1:0] seg_idx,
  output logic          seg_ready,
  output logic          busy,
  output logic [15:0]   tx_data,
  output logic [1:0]    tx_is_k
);

  localparam int DEPTH = NUM_SEG * SEG_BYTES;
  localparam int CW    = $clog2(COMMA_PERIOD);
  localparam int BW    = $clog2(BEACON_PERIOD);
  localparam int NW    = $clog2(SEG_BYTES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_DATA,
    S_STOP,
    S_CHK_H,
    S_CHK_L
  } state_t;

  state_t        state;
  logic          phase;
  logic [CW-1:0] cnt_c;
  logic [BW-1:0] cnt_b;
  logic          arm_ok;
  logic [SW-1:0] seg_q;
  logic [NW-1:0] byte_n;
  logic [15:0]   csum;
  logic [7:0]    rd_q;
  logic [AW-1:0] rd_addr;
  logic [7:0]    ram [DEPTH];

  logic          link_on;
  logic          comma_slot;
  logic          beacon_slot;
  logic          seg_accept;
  logic [7:0]    lsb_nxt;
  logic          lsbk_nxt;
  logic [7:0]    msb_nxt;
  logic          msbk_nxt;

  assign link_on     = link_ready & ~rst;
  assign comma_slot  = (cnt_c == '0);
  assign beacon_slot = (cnt_b == '0);
  assign evt_ready   = link_on & ~comma_slot & ~beacon_slot;
  assign seg_ready   = link_on & (state == S_IDLE);
  assign seg_accept  = seg_valid & seg_ready;
  assign rd_addr     = AW'(int'(seg_q) * SEG_BYTES + int'(byte_n));

  // Payload RAM: byte write port plus registered read; a same-address write returns old data.
  always_ff @(posedge clk) begin
    if (wr_en && int'(wr_addr) < DEPTH) ram[wr_addr] <= wr_data;
    rd_q <= ram[rd_addr];
  end

  // Next lane contents: event priority on the LSB lane, dbus/frame byte on the MSB lane.
  always_comb begin
    lsb_nxt  = '0;
    lsbk_nxt = 1'b0;
    msb_nxt  = '0;
    msbk_nxt = 1'b0;
    if (comma_slot) begin
      lsb_nxt  = 8'hBC;
      lsbk_nxt = 1'b1;
    end else if (beacon_slot) begin
      lsb_nxt = BEACON_CODE;
    end else if (evt_valid) begin
      lsb_nxt = evt_code;
    end
    if (!phase) begin
      msb_nxt = dbus;
    end else begin
      case (state)
        S_START: begin
          // START is held back one segment slot if the request was accepted too recently.
          if (arm_ok) begin
            msb_nxt  = 8'h5C;
            msbk_nxt = 1'b1;
          end
        end
        S_ADDR:  msb_nxt = 8'(seg_q);
        S_DATA:  msb_nxt = rd_q;
        S_STOP: begin
          msb_nxt  = 8'h3C;
          msbk_nxt = 1'b1;
        end
        S_CHK_H: msb_nxt = ~csum[15:8];
        S_CHK_L: msb_nxt = ~csum[7:0];
        default: msb_nxt = '0;
      endcase
    end
  end

  // Slot sequencing, frame FSM (advances on segment slots) and registered outputs.
  always_ff @(posedge clk) begin
    if (rst || !link_ready) begin
      state   <= S_IDLE;
      phase   <= 1'b0;
      cnt_c   <= '0;
      cnt_b   <= '0;
      arm_ok  <= 1'b0;
      seg_q   <= '0;
      byte_n  <= '0;
      csum    <= '0;
      busy    <= 1'b0;
      tx_data <= '0;
      tx_is_k <= '0;
    end else begin
      phase   <= ~phase;
      cnt_c   <= (cnt_c == CW'(COMMA_PERIOD - 1)) ? '0 : cnt_c + 1'b1;
      cnt_b   <= (cnt_b == BW'(BEACON_PERIOD - 1)) ? '0 : cnt_b + 1'b1;
      tx_data <= {msb_nxt, lsb_nxt};
      tx_is_k <= {msbk_nxt, lsbk_nxt};
      busy    <= seg_accept | (state != S_IDLE);
      if (state == S_START) arm_ok <= 1'b1;
      if (seg_accept) begin
        seg_q  <= seg_idx;
        state  <= S_START;
        arm_ok <= 1'b0;
      end
      if (phase) begin
        case (state)
          S_START: if (arm_ok) state <= S_ADDR;
          S_ADDR: begin
            csum   <= 16'(seg_q);
            byte_n <= '0;
            state  <= S_DATA;
          end
          S_DATA: begin
            csum <= csum + 16'(rd_q);
            if (byte_n == NW'(SEG_BYTES - 1)) state <= S_STOP;
            else byte_n <= byte_n + 1'b1;
          end
          S_STOP:  state <= S_CHK_H;
          S_CHK_H: state <= S_CHK_L;
          S_CHK_L: state <= S_IDLE;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sdb_frame_tx.sv
// Testbench for sdb_frame_tx: queue-based frame model plus directed and random stimulus.
module tb_sdb_frame_tx;

  localparam int         SB = 16;
  localparam int         NS = 16;
  localparam int         CP = 4;
  localparam int         BP = 7;
  localparam logic [7:0] BEACON = 8'h7E;

  logic        clk = 1'b0;
  logic        rst, link_ready, evt_valid, evt_ready, wr_en, seg_valid, seg_ready, busy;
  logic [7:0]  dbus, evt_code, wr_data, wr_addr;
  logic [3:0]  seg_idx;
  logic [15:0] tx_data;
  logic [1:0]  tx_is_k;

  sdb_frame_tx #(
    .SEG_BYTES(SB), .NUM_SEG(NS), .COMMA_PERIOD(CP), .BEACON_PERIOD(BP), .BEACON_CODE(BEACON)
  ) dut (
    .clk(clk), .rst(rst), .link_ready(link_ready), .dbus(dbus),
    .evt_valid(evt_valid), .evt_code(evt_code), .evt_ready(evt_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .seg_valid(seg_valid), .seg_idx(seg_idx), .seg_ready(seg_ready),
    .busy(busy), .tx_data(tx_data), .tx_is_k(tx_is_k)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model state
  logic [7:0]  mram [SB*NS];
  int          m_t = 0;
  bit          m_pend = 0;
  int          m_start = 0;
  logic [3:0]  m_seg = '0;
  logic [8:0]  m_q [$];
  logic [15:0] exp_data;
  logic [1:0]  exp_k;
  logic        exp_busy;
  bit          valid_exp = 0;
  int          out_t = -1;

  bit          pin_lsb = 0;
  bit          cap_en = 0;
  bit          cnt_en = 0;
  logic [8:0]  cap [$];
  int          hs_cnt = 0;
  int          lane_cnt = 0;

  // Compare DUT against the model, then advance the model to predict the next edge.
  always @(negedge clk) begin
    logic [7:0]  lsb, msb, b;
    logic        lk, mk;
    logic [15:0] sum, chk;
    bit          on, accept;
    on = !rst && link_ready;
    if (valid_exp) begin
      check("tx_data", tx_data, exp_data);
      check("tx_is_k", tx_is_k, exp_k);
      check("busy", busy, exp_busy);
      check("evt_ready", evt_ready, on && (m_t % CP != 0) && (m_t % BP != 0));
      check("seg_ready", seg_ready, on && !m_pend);
      if (pin_lsb) begin
        case (out_t)
          0:  check("pin_lsb_t0",  {tx_is_k[0], tx_data[7:0]}, 9'h1BC);
          1:  check("pin_lsb_t1",  {tx_is_k[0], tx_data[7:0]}, 9'h000);
          7:  check("pin_lsb_t7",  {tx_is_k[0], tx_data[7:0]}, 9'h07E);
          8:  check("pin_lsb_t8",  {tx_is_k[0], tx_data[7:0]}, 9'h1BC);
          14: check("pin_lsb_t14", {tx_is_k[0], tx_data[7:0]}, 9'h07E);
          28: check("pin_lsb_t28", {tx_is_k[0], tx_data[7:0]}, 9'h1BC);
          35: check("pin_lsb_t35", {tx_is_k[0], tx_data[7:0]}, 9'h07E);
          default: ;
        endcase
      end
      if (cap_en && out_t >= 0 && (out_t % 2) == 1) cap.push_back({tx_is_k[1], tx_data[15:8]});
      if (cnt_en) begin
        if (evt_valid && evt_ready) hs_cnt++;
        if (out_t >= 0 && tx_data[7:0] == 8'h23 && !tx_is_k[0]) lane_cnt++;
      end
    end

    if (wr_en) mram[wr_addr] = wr_data;
    if (!on) begin
      m_t = 0;
      m_q.delete();
      m_pend = 0;
      exp_data = '0;
      exp_k = '0;
      exp_busy = 1'b0;
      out_t = -1;
    end else begin
      lsb = '0; lk = 1'b0;
      if (m_t % CP == 0) begin lsb = 8'hBC; lk = 1'b1; end
      else if (m_t % BP == 0) lsb = BEACON;
      else if (evt_valid) lsb = evt_code;
      accept = seg_valid && !m_pend;
      exp_busy = accept || m_pend;
      msb = '0; mk = 1'b0;
      if (m_t % 2 == 0) msb = dbus;
      else if (m_pend && m_t >= m_start) begin
        {mk, msb} = m_q.pop_front();
        if (m_q.size() == 0) m_pend = 0;
      end
      if (accept) begin
        sum = 16'(seg_idx);
        m_q.push_back(9'h15C);
        m_q.push_back({1'b0, 4'h0, seg_idx});
        for (int i = 0; i < SB; i++) begin
          b = mram[int'(seg_idx) * SB + i];
          m_q.push_back({1'b0, b});
          sum = sum + 16'(b);
        end
        m_q.push_back(9'h13C);
        chk = 16'hFFFF - sum;
        m_q.push_back({1'b0, chk[15:8]});
        m_q.push_back({1'b0, chk[7:0]});
        m_pend = 1;
        m_start = m_t + 2;
        m_seg = seg_idx;
      end
      exp_data = {msb, lsb};
      exp_k = {mk, lk};
      out_t = m_t;
      m_t++;
    end
    valid_exp = 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] cap_at(input int i);
    return (i >= 0 && i < cap.size()) ? cap[i] : 9'h1FF;
  endfunction

  function automatic int cap_find(input int from, input logic [8:0] v);
    for (int i = from; i < cap.size(); i++) if (cap[i] == v) return i;
    return -1;
  endfunction

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((m_pend || busy) && n < 200) begin tick(); n++; end
    check(name, busy, 1'b0);
  endtask

  logic [8:0] exp3 [21];
  int base, s1, s2, hs0, ln0, wseg;

  initial begin
    rst = 1; link_ready = 0; dbus = '0; evt_valid = 0; evt_code = '0;
    wr_en = 0; wr_addr = '0; wr_data = '0; seg_valid = 0; seg_idx = '0;
    tick();
    rst = 0;
    for (int a = 0; a < SB*NS; a++) begin
      wr_en = 1; wr_addr = 8'(a); wr_data = 8'($urandom); tick();
    end
    wr_en = 0;

    // Reset with link up, then default comma/beacon pattern
    link_ready = 1; rst = 1; dbus = 8'hA5;
    repeat (3) tick();
    rst = 0; pin_lsb = 1;
    for (int i = 0; i < 40; i++) begin dbus = 8'($urandom); tick(); end
    pin_lsb = 0;

    // Segment 4 filled with 0x01
    for (int i = 0; i < SB; i++) begin
      wr_en = 1; wr_addr = 8'(4*SB + i); wr_data = 8'h01; tick();
    end
    wr_en = 0;
    wait_idle("t3_idle_before");
    base = cap.size(); cap_en = 1;
    seg_valid = 1; seg_idx = 4'd4; tick(); seg_valid = 0;
    wait_idle("t3_frame_end");
    repeat (4) tick();
    cap_en = 0;
    exp3[0] = 9'h15C; exp3[1] = 9'h004;
    for (int i = 0; i < SB; i++) exp3[2+i] = 9'h001;
    exp3[18] = 9'h13C; exp3[19] = 9'h0FF; exp3[20] = 9'h0EB;
    s1 = cap_find(base, 9'h15C);
    check("t3_start_found", s1 >= 0, 1'b1);
    for (int i = 0; i < 21; i++) check($sformatf("t3_byte%0d", i), cap_at(s1 + i), exp3[i]);
    check("t3_trailing_idle", cap_at(s1 + 21), 9'h000);

    // Held event code
    hs0 = hs_cnt; ln0 = lane_cnt;
    evt_code = 8'h23; evt_valid = 1; cnt_en = 1;
    repeat (40) tick();
    evt_valid = 0; tick(); cnt_en = 0;
    check("t4_hs_vs_lane", hs_cnt - hs0, lane_cnt - ln0);
    check("t4_hs_nonzero", (hs_cnt - hs0) > 0, 1'b1);
    check("t4_hs_below_cycles", (hs_cnt - hs0) < 40, 1'b1);

    // Link drop mid-DATA, then recovery
    wait_idle("t5_idle_before");
    seg_valid = 1; seg_idx = 4'd5; tick(); seg_valid = 0;
    repeat (12) tick();
    link_ready = 0; tick();
    check("t5_busy_drop", busy, 1'b0);
    check("t5_data_drop", {tx_is_k, tx_data}, 18'h0);
    repeat (2) tick();
    link_ready = 1; #1;
    check("t5_seg_ready_back", seg_ready, 1'b1);
    base = cap.size(); cap_en = 1;
    seg_valid = 1; seg_idx = 4'd6; tick(); seg_valid = 0;
    wait_idle("t5_frame_end");
    cap_en = 0;
    s1 = base;
    while (s1 < cap.size() && cap[s1] == 9'h000) s1++;
    check("t5_first_byte_start", cap_at(s1), 9'h15C);

    // Back-to-back requests for segments 1 and 2
    for (int i = 0; i < SB; i++) begin
      wr_en = 1; wr_addr = 8'(1*SB + i); wr_data = 8'(i); tick();
    end
    for (int i = 0; i < SB; i++) begin
      wr_en = 1; wr_addr = 8'(2*SB + i); wr_data = 8'(8'h10 + i); tick();
    end
    wr_en = 0;
    wait_idle("t6_idle_before");
    base = cap.size(); cap_en = 1;
    seg_valid = 1; seg_idx = 4'd1; tick();
    seg_idx = 4'd2;
    for (int n = 0; n < 200; n++) begin
      if (m_pend && m_seg == 4'd2) break;
      tick();
    end
    seg_valid = 0;
    check("t6_second_accepted", m_seg, 4'd2);
    wait_idle("t6_frame_end");
    repeat (2) tick();
    cap_en = 0;
    s1 = cap_find(base, 9'h15C);
    s2 = cap_find(s1 + 1, 9'h15C);
    check("t6_f1_addr", cap_at(s1 + 1), 9'h001);
    check("t6_f1_chk_h", cap_at(s1 + 19), 9'h0FF);
    check("t6_f1_chk_l", cap_at(s1 + 20), 9'h086);
    check("t6_gap_slots", s2 - s1 - 21, 1);
    check("t6_gap_idle", cap_at(s1 + 21), 9'h000);
    check("t6_f2_addr", cap_at(s2 + 1), 9'h002);
    check("t6_f2_chk_h", cap_at(s2 + 19), 9'h0FE);
    check("t6_f2_chk_l", cap_at(s2 + 20), 9'h085);

    // Randomised traffic; RAM writes avoid the segment currently in flight
    for (int n = 0; n < 4000; n++) begin
      rst        = ($urandom_range(299) == 0);
      link_ready = ($urandom_range(149) != 0);
      dbus       = 8'($urandom);
      evt_valid  = 1'($urandom);
      evt_code   = 8'($urandom);
      seg_valid  = ($urandom_range(5) == 0);
      seg_idx    = 4'($urandom);
      wr_en      = ($urandom_range(2) == 0);
      wseg       = $urandom_range(NS - 1);
      if (m_pend && wseg == int'(m_seg)) wseg = (wseg + 1) % NS;
      wr_addr    = 8'(wseg * SB + $urandom_range(SB - 1));
      wr_data    = 8'($urandom);
      tick();
    end
    rst = 0; link_ready = 1; seg_valid = 0; evt_valid = 0; wr_en = 0;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
